// File: rtl/multicycle_cpu.sv
// Small accumulator-style multicycle CPU: FETCH/EXEC/MEM/HALT sequencer
// with a separate program port and a request/acknowledge data memory port.
module multicycle_cpu #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [AW-1:0]   p_addr_o,
    input  logic [3+AW:0]   p_data_i,
    output logic [AW-1:0]   r_addr_o,
    input  logic [DW-1:0]   r_data_i,
    output logic [DW-1:0]   r_data_o,
    output logic            r_re_o,
    output logic            r_we_o,
    input  logic            r_ack_i,
    output logic            halt_o,
    output logic [1:0]      state_o
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;
    localparam logic [3:0] OP_MOV = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_JNZ = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic [3+AW:0] ir;
    logic [DW-1:0] a, b, r;
    logic          c, z;

    logic [3:0]    opcode;
    logic [AW-1:0] operand;
    logic [DW-1:0] imm;
    logic [AW-1:0] pc_inc;
    logic [DW:0]   sum, diff;
    logic [DW-1:0] alu_r;
    logic          alu_c;
    logic          alu_op;

    assign opcode  = ir[3+AW:AW];
    assign operand = ir[AW-1:0];
    assign imm     = DW'(operand);
    assign pc_inc  = pc + AW'(1);
    // The extra top bit of the difference is the borrow, i.e. a < b unsigned.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign alu_op  = (opcode >= OP_ADD) && (opcode <= OP_XOR);

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        case (opcode)
            OP_ADD: {alu_c, alu_r} = sum;
            OP_SUB: {alu_c, alu_r} = diff;
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            r     <= '0;
            c     <= 1'b0;
            z     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= p_data_i;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    pc    <= pc_inc;
                    if (alu_op) begin
                        r <= alu_r;
                        c <= alu_c;
                        z <= (alu_r == '0);
                    end
                    case (opcode)
                        OP_NOP: ;
                        OP_LDA: a <= imm;
                        OP_LDB: b <= imm;
                        OP_LD, OP_ST: begin
                            state <= MEM;
                            pc    <= pc;
                        end
                        OP_MOV: a <= r;
                        OP_JMP: pc <= operand;
                        OP_JZ:  if (z)  pc <= operand;
                        OP_JC:  if (c)  pc <= operand;
                        OP_JNZ: if (!z) pc <= operand;
                        OP_HLT: begin
                            state <= HALT;
                            pc    <= pc;
                        end
                        default: ;
                    endcase
                end
                // Strobe stays up with address/data held until an ack is
                // sampled on a rising edge; that edge completes the access.
                MEM: begin
                    if (r_ack_i) begin
                        if (opcode == OP_LD) a <= r_data_i;
                        pc    <= pc_inc;
                        state <= FETCH;
                    end
                end
                HALT: ;
                default: state <= FETCH;
            endcase
        end
    end

    assign p_addr_o = pc;
    assign r_addr_o = operand;
    assign r_data_o = r;
    assign r_re_o   = (state == MEM) && (opcode == OP_LD);
    assign r_we_o   = (state == MEM) && (opcode == OP_ST);
    assign halt_o   = (state == HALT);
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu (DW=4, AW=4): program table, data
// memory responder with programmable ack delay, and store scoreboard.
module tb_multicycle_cpu;

    logic        clk_i;
    logic        rst_i;
    logic [3:0]  p_addr_o;
    logic [7:0]  p_data_i;
    logic [3:0]  r_addr_o;
    logic [3:0]  r_data_i;
    logic [3:0]  r_data_o;
    logic        r_re_o;
    logic        r_we_o;
    logic        r_ack_i;
    logic        halt_o;
    logic [1:0]  state_o;

    multicycle_cpu #(.DW(4), .AW(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .p_addr_o (p_addr_o),
        .p_data_i (p_data_i),
        .r_addr_o (r_addr_o),
        .r_data_i (r_data_i),
        .r_data_o (r_data_o),
        .r_re_o   (r_re_o),
        .r_we_o   (r_we_o),
        .r_ack_i  (r_ack_i),
        .halt_o   (halt_o),
        .state_o  (state_o)
    );

    typedef struct {
        logic [15:0][7:0] prog;
        int               delay;
        int               n_st;
        logic [7:0]       st0;
        logic [7:0]       st1;
        logic [3:0]       exp_pc;
        logic [3:0]       exp_r;
        int               exp_cyc;
    } vec_t;

    logic [7:0] prog_mem [16];
    logic [3:0] dmem [16];
    logic [7:0] exp_q [$];
    int         ack_delay;
    int         checks;
    int         errors;
    vec_t       vecs [8];

    assign p_data_i = prog_mem[p_addr_o];

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic assert_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_p_addr", p_addr_o, 0);
        check("rst_r_addr", r_addr_o, 0);
        check("rst_r_data", r_data_o, 0);
        check("rst_re", r_re_o, 0);
        check("rst_we", r_we_o, 0);
        check("rst_halt", halt_o, 0);
        check("rst_state", state_o, 0);
        @(negedge clk_i);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (halt_o) break;
        end
    endtask

    // ---------------- data memory responder / scoreboard ----------------
    initial begin
        int         cnt;
        logic [3:0] s_addr, s_data;
        logic [7:0] e;
        cnt = 0;
        s_addr = '0;
        s_data = '0;
        forever begin
            @(negedge clk_i);
            if (r_re_o || r_we_o) begin
                check("strobe_excl", {31'b0, r_re_o & r_we_o}, 0);
                if (cnt == 0) begin
                    s_addr = r_addr_o;
                    s_data = r_data_o;
                end else begin
                    check("addr_stable", r_addr_o, s_addr);
                    check("data_stable", r_data_o, s_data);
                end
                if (cnt == ack_delay) begin
                    r_ack_i = 1'b1;
                    if (r_re_o) begin
                        r_data_i = dmem[r_addr_o];
                    end else begin
                        if (exp_q.size() == 0) begin
                            check("store_unexpected", {24'b0, r_addr_o, r_data_o}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("store", {r_addr_o, r_data_o}, e);
                        end
                        dmem[r_addr_o] = r_data_o;
                    end
                    cnt = 0;
                end else begin
                    r_ack_i  = 1'b0;
                    r_data_i = 4'($urandom);
                    cnt++;
                end
            end else begin
                // Random acks outside an access must be ignored by the DUT.
                r_ack_i  = 1'($urandom_range(0, 1));
                r_data_i = 4'($urandom);
                cnt = 0;
            end
        end
    end

    function automatic logic [15:0][7:0] mkprog(input logic [127:0] x);
        for (int i = 0; i < 16; i++) mkprog[i] = x[8*(15-i) +: 8];
    endfunction

    task automatic load_prog(input logic [15:0][7:0] p);
        for (int i = 0; i < 16; i++) begin
            prog_mem[i] = p[i];
            dmem[i]     = 4'(i) ^ 4'h8;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        checks    = 0;
        errors    = 0;
        rst_i     = 1'b0;
        r_ack_i   = 1'b0;
        r_data_i  = '0;
        ack_delay = 0;
        for (int i = 0; i < 16; i++) prog_mem[i] = 8'h00;

        vecs[0] = '{mkprog(128'h192850F0_00000000_00000000_00000000), 0, 0, 8'h00, 8'h00, 4'h3, 4'h1, 8};
        vecs[1] = '{mkprog(128'h132360C7_F00000F0_00000000_00000000), 0, 0, 8'h00, 8'h00, 4'h7, 4'h0, 10};
        vecs[2] = '{mkprog(128'h132460C7_D9F000F0_00F00000_00000000), 0, 0, 8'h00, 8'h00, 4'h9, 4'hF, 12};
        vecs[3] = '{mkprog(128'h13255045_F0000000_00000000_00000000), 3, 1, 8'h58, 8'h00, 4'h4, 4'h8, 14};
        vecs[4] = '{mkprog(128'h13246032_D6F02050_4EF00000_00000000), 1, 1, 8'hEA, 8'h00, 4'h9, 4'hA, 22};
        vecs[5] = '{mkprog(128'h1C2A7040_804190F0_00000000_00000000), 0, 2, 8'h08, 8'h1E, 4'h7, 4'h6, 18};
        vecs[6] = '{mkprog(128'h112150A0_50E7F0B9_F04FF000_00000000), 2, 1, 8'hF3, 8'h00, 4'hA, 4'h3, 21};
        vecs[7] = '{mkprog(128'h10216070_D6C7F0F0_00000000_00000000), 0, 0, 8'h00, 8'h00, 4'h7, 4'h0, 14};

        for (int v = 0; v < 8; v++) begin
            assert_reset();
            load_prog(vecs[v].prog);
            ack_delay = vecs[v].delay;
            exp_q.delete();
            if (vecs[v].n_st > 0) exp_q.push_back(vecs[v].st0);
            if (vecs[v].n_st > 1) exp_q.push_back(vecs[v].st1);
            release_reset();
            run_to_halt(cyc);
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
            check($sformatf("v%0d_halt", v), halt_o, 1);
            check($sformatf("v%0d_pc", v), p_addr_o, vecs[v].exp_pc);
            check($sformatf("v%0d_r", v), r_data_o, vecs[v].exp_r);
            check($sformatf("v%0d_stores_left", v), exp_q.size(), 0);
            @(negedge clk_i);
            check($sformatf("v%0d_halt_hold", v), halt_o, 1);
            check($sformatf("v%0d_pc_hold", v), p_addr_o, vecs[v].exp_pc);
            check($sformatf("v%0d_strobes_halt", v), {r_re_o, r_we_o}, 0);
        end

        // PC wraps from F to 0 after a NOP at the top of program space.
        assert_reset();
        for (int i = 0; i < 16; i++) prog_mem[i] = 8'h00;
        prog_mem[0] = 8'hBF;
        release_reset();
        @(posedge clk_i); @(negedge clk_i);
        check("wrap_exec_state", state_o, 1);
        check("wrap_exec_pc", p_addr_o, 0);
        @(posedge clk_i); @(negedge clk_i);
        check("wrap_jmp_pc", p_addr_o, 4'hF);
        @(posedge clk_i); @(negedge clk_i);
        @(posedge clk_i); @(negedge clk_i);
        check("wrap_pc", p_addr_o, 0);
        check("wrap_state", state_o, 0);

        // Reset pulse in the middle of an acknowledged LD.
        assert_reset();
        for (int i = 0; i < 16; i++) prog_mem[i] = 8'h00;
        prog_mem[0] = 8'h31;
        for (int i = 0; i < 16; i++) dmem[i] = 4'(i) ^ 4'h8;
        ack_delay = 0;
        exp_q.delete();
        release_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        check("mrst_re_before", r_re_o, 1);
        #1 rst_i = 1'b0;
        #1;
        check("mrst_re", r_re_o, 0);
        check("mrst_we", r_we_o, 0);
        check("mrst_pc", p_addr_o, 0);
        check("mrst_state", state_o, 0);
        prog_mem[0] = 8'h20;
        prog_mem[1] = 8'h50;
        prog_mem[2] = 8'h40;
        prog_mem[3] = 8'hF0;
        exp_q.push_back(8'h00);
        #1 rst_i = 1'b1;
        run_to_halt(cyc);
        check("mrst_cycles", cyc, 9);
        check("mrst_halt_pc", p_addr_o, 3);
        check("mrst_r", r_data_o, 0);
        check("mrst_stores_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter DW, 4, data/register width in bits (DW >= 2) SHALL be supported.
REQ-002 Parameter AW, 4, program and data address width in bits (AW >= 2) SHALL be supported.
REQ-003 clk_i  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_i  input  1  reset; asynchronous and active-low.
REQ-005 p_addr_o  output  AW  program address; SHALL equal PC.
REQ-006 p_data_i  input  4+AW  instruction; [3+AW:AW] opcode, [AW-1:0] operand; valid combinationally for the current p_addr_o.
REQ-007 r_addr_o  output  AW  data address; SHALL equal the IR operand field.
REQ-008 r_data_i  input  DW  data memory read data; sampled on the r_ack_i cycle.
REQ-009 r_data_o  output  DW  data memory write data; SHALL equal register R.
REQ-010 r_re_o  output  1  read request.
REQ-011 r_we_o  output  1  write request.
REQ-012 r_ack_i  input  1  data memory acknowledge.
REQ-013 halt_o  output  1  high while in HALT.

Function
REQ-014 Internal state SHALL be PC (AW bits), IR (4+AW bits), A, B and R (DW bits each), C and Z flags, and an FSM with states FETCH, EXEC, MEM and HALT.
REQ-015 FETCH SHALL load IR from p_data_i and go to EXEC in 1 cycle.
REQ-016 EXEC SHALL execute a non-memory opcode, update PC and return to FETCH, so every non-memory instruction takes exactly 2 cycles.
REQ-017 In EXEC, LD and ST SHALL go to MEM without changing PC.
REQ-018 In MEM, r_re_o (LD) or r_we_o (ST) SHALL be held high with r_addr_o and r_data_o stable until r_ack_i is sampled high.
REQ-019 On the r_ack_i cycle, MEM SHALL complete the access, set PC <= PC+1 and go to FETCH; a memory instruction takes at least 3 cycles.
REQ-020 r_re_o and r_we_o SHALL be low in every state other than MEM and SHALL never be high together; r_ack_i SHALL be ignored outside MEM.
REQ-021 The immediate imm SHALL be the operand zero-extended or truncated to DW bits.
REQ-022 Opcodes: 0 NOP; 1 LDA A<=imm; 2 LDB B<=imm; 3 LD A<=mem[op]; 4 ST mem[op]<=R; 5 ADD; 6 SUB; 7 AND; 8 OR; 9 XOR; A MOV A<=R; B JMP; C JZ; D JC; E JNZ; F HLT.
REQ-023 ADD SHALL set R<=(A+B) mod 2^DW and C<=carry-out of bit DW-1.
REQ-024 SUB SHALL set R<=(A-B) mod 2^DW and C<=1 exactly when A<B unsigned.
REQ-025 AND, OR and XOR SHALL write R and clear C.
REQ-026 Opcodes 5-9 SHALL set Z<=(new R==0); all other opcodes SHALL leave C and Z unchanged.
REQ-027 JMP SHALL load PC<=op unconditionally.
REQ-028 JZ, JC and JNZ SHALL load PC<=op when Z=1, C=1 and Z=0 respectively, and otherwise PC<=PC+1.
REQ-029 PC+1 SHALL wrap from 2^AW-1 to 0.
REQ-030 HLT SHALL go to HALT without changing PC; HALT SHALL be left only by reset, and halt_o SHALL be 1 exactly in HALT.
REQ-031 A jump in EXEC SHALL take effect on the next p_addr_o, with no delay slot.

Reset
REQ-032 rst_i low SHALL immediately, without waiting for clk_i, set PC, IR, A, B, R, C and Z to 0 and the FSM to FETCH.
REQ-033 While rst_i is low, outputs SHALL be p_addr_o=0, r_addr_o=0, r_data_o=0, r_re_o=0, r_we_o=0 and halt_o=0.
REQ-034 Reset asserted during MEM SHALL drop r_re_o/r_we_o asynchronously and abandon the access; an r_ack_i in the same cycle SHALL be ignored.
REQ-035 After rst_i rises, the first FETCH SHALL occur on the first rising clk_i edge.

Verification (DW=4, AW=4)
REQ-036 Program LDA 9; LDB 8; ADD; HLT -> R=1, C=1, Z=0, halt_o=1 on cycle 8, PC=3.
REQ-037 LDA 3; LDB 3; SUB; JZ 7 -> Z=1, C=0, PC=7 on the next fetch; with LDB 4 instead -> R=F, C=1, PC=4.
REQ-038 ST 5 with r_ack_i delayed 3 cycles -> r_we_o high for 4 cycles, r_addr_o=5, r_data_o=R stable throughout, then PC advances by 1.
REQ-039 LD 2 with r_data_i=A on the ack cycle -> A=A; C and Z unchanged.
REQ-040 PC=F executing NOP -> next p_addr_o=0.
REQ-041 rst_i pulsed low mid-MEM with r_ack_i high -> strobes drop the same instant, A is not written, and execution restarts at PC=0.
